// File: rtl/elevator_ctrl_if.sv
// Button, countdown and indicator bundle between the elevator controller and
// its surroundings (bench, counting block, display drivers).
//   btn_stable_shot : one-cycle shots, [0] power/park, [1] move, [2] door hold
//   counting_value  : countdown digit 0..5 from the counting block
//   state           : controller state, fed back to the counting block
//   current_floor, door_open, motor_up, motor_down, pending_req : indicators
//   trip_count      : completed arrivals, wrapping
//   seg_count, seg_floor : {g,f,e,d,c,b,a} active-high seven-segment patterns
interface elevator_ctrl_if;
    logic [2:0] btn_stable_shot;
    logic [2:0] counting_value;
    logic [2:0] state;
    logic       current_floor;
    logic       door_open;
    logic       motor_up;
    logic       motor_down;
    logic       pending_req;
    logic [7:0] trip_count;
    logic [6:0] seg_count;
    logic [6:0] seg_floor;

    modport master (
        output btn_stable_shot, counting_value,
        input  state, current_floor, door_open, motor_up, motor_down,
               pending_req, trip_count, seg_count, seg_floor
    );

    modport slave (
        input  btn_stable_shot, counting_value,
        output state, current_floor, door_open, motor_up, motor_down,
               pending_req, trip_count, seg_count, seg_floor
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Two-floor elevator controller. Sequences idle/parked/travelling states from
// button shots and the counting block's countdown, and decodes door, motor
// and seven-segment indicators.
//   clk : 10 kHz system clock
//   rst : asynchronous active-high reset
//   bus : elevator_ctrl_if.slave (buttons and countdown in, indicators out)
module elevator_ctrl (
    input  logic           clk,
    input  logic           rst,
    elevator_ctrl_if.slave bus
);
    localparam int unsigned TRIP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLOOR1     = 3'd1,
        ST_FLOOR2     = 3'd2,
        ST_GOING_TO_1 = 3'd3,
        ST_GOING_TO_2 = 3'd4
    } state_t;

    state_t              state;
    logic                current_floor;
    logic                pending_req;
    logic                armed;
    logic [TRIP_W-1:0]   trip_count;

    logic                cv_zero;
    logic                pwr_btn;
    logic                move_btn;

    assign cv_zero  = (bus.counting_value == 3'd0);
    assign pwr_btn  = bus.btn_stable_shot[0];
    assign move_btn = bus.btn_stable_shot[1];

    // Main FSM. armed defaults to "seen a nonzero count"; every transition
    // below overrides it to 0 so a stale zero at state entry is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            current_floor <= 1'b0;
            pending_req   <= 1'b0;
            armed         <= 1'b0;
            trip_count    <= '0;
        end else begin
            armed <= armed | ~cv_zero;
            case (state)
                ST_IDLE: begin
                    if (pwr_btn) begin
                        state <= current_floor ? ST_FLOOR2 : ST_FLOOR1;
                        armed <= 1'b0;
                    end
                end
                ST_FLOOR1, ST_FLOOR2: begin
                    if (move_btn) begin
                        state <= (state == ST_FLOOR1) ? ST_GOING_TO_2 : ST_GOING_TO_1;
                        armed <= 1'b0;
                    end else if (pending_req && armed && cv_zero) begin
                        state       <= (state == ST_FLOOR1) ? ST_GOING_TO_2 : ST_GOING_TO_1;
                        pending_req <= 1'b0;
                        armed       <= 1'b0;
                    end else if (pwr_btn && cv_zero) begin
                        state <= ST_IDLE;
                        armed <= 1'b0;
                    end
                end
                ST_GOING_TO_1, ST_GOING_TO_2: begin
                    if (move_btn) begin
                        pending_req <= 1'b1;
                    end
                    if (armed && cv_zero) begin
                        state         <= (state == ST_GOING_TO_1) ? ST_FLOOR1 : ST_FLOOR2;
                        current_floor <= (state == ST_GOING_TO_2);
                        trip_count    <= trip_count + TRIP_W'(1);
                        armed         <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

    // Digit to {g,f,e,d,c,b,a}; out-of-range digits show a dash.
    function automatic logic [6:0] seg7(input logic [2:0] d);
        case (d)
            3'd0:    seg7 = 7'h3F;
            3'd1:    seg7 = 7'h06;
            3'd2:    seg7 = 7'h5B;
            3'd3:    seg7 = 7'h4F;
            3'd4:    seg7 = 7'h66;
            3'd5:    seg7 = 7'h6D;
            default: seg7 = 7'h40;
        endcase
    endfunction

    // Floor digit: parked floor or travel destination, dash when idle.
    always_comb begin
        bus.seg_floor = 7'h40;
        case (state)
            ST_FLOOR1, ST_GOING_TO_1: bus.seg_floor = seg7(3'd1);
            ST_FLOOR2, ST_GOING_TO_2: bus.seg_floor = seg7(3'd2);
            default:                  bus.seg_floor = 7'h40;
        endcase
    end

    assign bus.state         = state;
    assign bus.current_floor = current_floor;
    assign bus.pending_req   = pending_req;
    assign bus.trip_count    = trip_count;
    assign bus.door_open     = ((state == ST_FLOOR1) || (state == ST_FLOOR2)) && !cv_zero;
    assign bus.motor_up      = (state == ST_GOING_TO_2);
    assign bus.motor_down    = (state == ST_GOING_TO_1);
    assign bus.seg_count     = seg7(bus.counting_value);

endmodule
